alu_op_issuer: RTL and testbench

// - Producer side of the 32-bit ALU interface: decodes MIPS instruction words into ALUOperation, A, B and Shamt.
// - Registers them into a small FIFO (skid) buffer and hands them to the ALU/EX stage over a valid/ready handshake.
// - Sits between the register-file read stage and the ALU. Rejects opcodes/functs the ALU does not implement.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_issuer_if.sv | 26 ++
 rtl/alu_op_decode.sv | 64 ++++++
 rtl/alu_op_issuer.sv | 90 +++++++++
 tb/tb_alu_op_issuer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: 4-bit ALU op codes, MIPS opcode/funct constants, request struct.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
  } alu_req_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Issuer bus: instruction/operand input handshake and decoded ALU request output handshake.
// master = issuer side, slave = upstream register-read stage plus downstream ALU/EX stage.
interface alu_op_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        illegal;

  modport master (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, ALUOperation, A, B, Shamt, illegal
  );

  modport slave (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, ALUOperation, A, B, Shamt, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode into an ALU request; legal=0 for opcodes/functs the ALU lacks.
// Zero latency, no handshake of its own.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output alu_req_t    req,
  output logic        legal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  // Register-specifier fields arrive already resolved as rs_data/rt_data.
  logic        unused_reg_fields;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign imm               = instr[15:0];
  assign unused_reg_fields = ^instr[25:16];

  always_comb begin
    req   = '0;
    legal = 1'b1;
    req.A = rs_data;
    case (opcode)
      OPC_RTYPE: begin
        req.B     = rt_data;
        req.Shamt = instr[10:6];
        case (funct)
          FN_AND:  req.op = ALU_AND;
          FN_OR:   req.op = ALU_OR;
          FN_NOR:  req.op = ALU_NOR;
          FN_ADD:  req.op = ALU_ADD;
          FN_SUB:  req.op = ALU_SUB;
          FN_SLL:  req.op = ALU_SLL;
          FN_SRL:  req.op = ALU_SRL;
          default: legal  = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        req.op = ALU_ADD;
        req.B  = {{16{imm[15]}}, imm};
      end
      OPC_ANDI: begin
        req.op = ALU_AND;
        req.B  = {16'h0000, imm};
      end
      OPC_ORI: begin
        req.op = ALU_OR;
        req.B  = {16'h0000, imm};
      end
      // The ALU itself shifts the immediate into the upper half.
      OPC_LUI: begin
        req.op = ALU_LUI;
        req.B  = {16'h0000, imm};
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Decodes instructions into a DEPTH-entry FIFO feeding the ALU; 1 cycle in->out, in_ready = not full
// (independent of out_ready). `ALU_ISSUE_CNT_EN adds issued_cnt/illegal_cnt outputs.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_op_issuer_if.master      bus
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] issued_cnt,
  output logic [CNT_WIDTH-1:0] illegal_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  alu_req_t        mem [DEPTH];
  alu_req_t        dec_req;
  alu_req_t        head;
  logic            dec_legal;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            illegal_q;
  logic            accept;
  logic            push;
  logic            pop;

  alu_op_decode u_decode (
    .instr   (bus.instr),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data),
    .req     (dec_req),
    .legal   (dec_legal)
  );

  assign bus.in_ready  = (count < FULL);
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && dec_legal;
  assign pop           = bus.out_valid && bus.out_ready;

  // Gating by out_valid makes the outputs read zero the moment reset empties the buffer.
  assign head             = bus.out_valid ? mem[rptr] : '0;
  assign bus.ALUOperation = head.op;
  assign bus.A            = head.A;
  assign bus.B            = head.B;
  assign bus.Shamt        = head.Shamt;
  assign bus.illegal      = illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      illegal_q <= accept && !dec_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec_req;
  end

`ifdef ALU_ISSUE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (pop)                   issued_cnt  <= issued_cnt + CNT_WIDTH'(1);
      if (accept && !dec_legal)  illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized bench for alu_op_issuer against a queue-based reference model, plus directed literal checks.
module tb_alu_op_issuer;
  localparam int DEPTH = 2;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_issuer_if bus();

`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] issued_cnt;
  logic [15:0] illegal_cnt;
`endif

  alu_op_issuer #(.DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  exp_t        mq[$];
  bit          exp_ill  = 1'b0;
  logic [15:0] exp_iss_n = '0;
  logic [15:0] exp_ill_n = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                  output bit ok, output exp_t e);
    logic [15:0] imm;
    imm  = ins[15:0];
    ok   = 1'b1;
    e.a  = rs;
    e.b  = 32'h0;
    e.sh = 5'd0;
    e.op = 4'h0;
    if (ins[31:26] == 6'h00) begin
      e.b  = rt;
      e.sh = ins[10:6];
      case (ins[5:0])
        6'h24: e.op = 4'b0000;
        6'h25: e.op = 4'b0001;
        6'h27: e.op = 4'b0010;
        6'h20: e.op = 4'b0011;
        6'h22: e.op = 4'b0100;
        6'h00: e.op = 4'b0101;
        6'h02: e.op = 4'b0111;
        default: ok = 1'b0;
      endcase
    end else if (ins[31:26] == 6'h08) begin
      e.op = 4'b0011;
      e.b  = {{16{imm[15]}}, imm};
    end else if (ins[31:26] == 6'h0C) begin
      e.op = 4'b0000;
      e.b  = {16'h0, imm};
    end else if (ins[31:26] == 6'h0D) begin
      e.op = 4'b0001;
      e.b  = {16'h0, imm};
    end else if (ins[31:26] == 6'h0F) begin
      e.op = 4'b1111;
      e.b  = {16'h0, imm};
    end else begin
      ok = 1'b0;
    end
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {6'h00, regs, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [15:0] imm);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {opc, regs, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [8];
    logic [5:0] fn;
    int         sel;
    fns = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h00, 6'h02, 6'h2A};
    sel = $urandom_range(0, 9);
    if (sel <= 4) begin
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      return mk_r(fn, 5'($urandom));
    end
    case (sel)
      5:       return mk_i(6'h08, 16'($urandom));
      6:       return mk_i(6'h0C, 16'($urandom));
      7:       return mk_i(6'h0D, 16'($urandom));
      8:       return mk_i(6'h0F, 16'($urandom));
      default: return $urandom;
    endcase
  endfunction

  task automatic compare_all();
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
    chk("illegal",   32'(bus.illegal),   32'(exp_ill));
    if (mq.size() != 0) begin
      chk("ALUOperation", 32'(bus.ALUOperation), 32'(mq[0].op));
      chk("A",            bus.A,                 mq[0].a);
      chk("B",            bus.B,                 mq[0].b);
      chk("Shamt",        32'(bus.Shamt),        32'(mq[0].sh));
    end
`ifdef ALU_ISSUE_CNT_EN
    chk("issued_cnt",  32'(issued_cnt),  32'(exp_iss_n));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(exp_ill_n));
`endif
  endtask

  // Called at a falling edge: drive inputs, advance the model across the rising edge, then compare.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy);
    bit   acc;
    bit   ok;
    exp_t e;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs_data   = rs;
    bus.rt_data   = rt;
    bus.out_ready = ordy;
    @(posedge clk);
    acc = v && (mq.size() < DEPTH);
    ref_dec(ins, rs, rt, ok, e);
    if (mq.size() != 0 && ordy) begin
      void'(mq.pop_front());
      exp_iss_n++;
    end
    if (acc && ok) mq.push_back(e);
    exp_ill = acc && !ok;
    if (exp_ill) exp_ill_n++;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst illegal",   32'(bus.illegal),   32'd0);
    chk("rst ALUOp",     32'(bus.ALUOperation), 32'd0);
    reset = 1'b0;
    compare_all();

    // Decode of each operand shape, with literal pins.
    cycle(1'b1, mk_r(6'h20, 5'd0), 32'd5, 32'd7, 1'b0);
    chk("add out_valid", 32'(bus.out_valid), 32'd1);
    chk("add op", 32'(bus.ALUOperation), 32'h3);
    chk("add A", bus.A, 32'd5);
    chk("add B", bus.B, 32'd7);
    cycle(1'b1, mk_i(6'h08, 16'hFFFF), 32'd1, 32'hDEAD_BEEF, 1'b1);
    chk("addi B", bus.B, 32'hFFFF_FFFF);
    chk("addi op", 32'(bus.ALUOperation), 32'h3);
    cycle(1'b1, mk_i(6'h0F, 16'h1234), 32'd0, 32'd0, 1'b1);
    chk("lui op", 32'(bus.ALUOperation), 32'hF);
    chk("lui B", bus.B, 32'h0000_1234);
    cycle(1'b1, mk_r(6'h00, 5'd4), 32'd9, 32'd1, 1'b1);
    chk("sll op", 32'(bus.ALUOperation), 32'h5);
    chk("sll Shamt", 32'(bus.Shamt), 32'd4);
    chk("sll B", bus.B, 32'd1);
    cycle(1'b1, mk_r(6'h02, 5'd31), 32'd3, 32'h8000_0000, 1'b1);
    chk("srl op", 32'(bus.ALUOperation), 32'h7);
    chk("srl Shamt", 32'(bus.Shamt), 32'd31);
    cycle(1'b0, '0, '0, '0, 1'b1);

    // Fill to DEPTH with the ALU stalled, then release.
    cycle(1'b1, mk_r(6'h25, 5'd0), 32'h11, 32'h1, 1'b0);
    cycle(1'b1, mk_r(6'h24, 5'd0), 32'h22, 32'h2, 1'b0);
    chk("full in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, mk_r(6'h22, 5'd0), 32'h33, 32'h3, 1'b0);
    chk("full head held", bus.A, 32'h11);
    cycle(1'b1, mk_r(6'h22, 5'd0), 32'h33, 32'h3, 1'b1);
    chk("order 2nd", bus.A, 32'h22);
    cycle(1'b1, mk_r(6'h22, 5'd0), 32'h33, 32'h3, 1'b1);
    chk("order 3rd", bus.A, 32'h33);
    chk("3rd op", 32'(bus.ALUOperation), 32'h4);
    cycle(1'b0, '0, '0, '0, 1'b1);

    // Rejected instructions.
    cycle(1'b1, mk_i(6'h23, 16'h0004), 32'd1, 32'd2, 1'b1);
    chk("lw illegal", 32'(bus.illegal), 32'd1);
    chk("lw out_valid", 32'(bus.out_valid), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
    chk("lw illegal_cnt", 32'(illegal_cnt), 32'd1);
`endif
    cycle(1'b0, '0, '0, '0, 1'b1);
    chk("illegal one cycle", 32'(bus.illegal), 32'd0);
    cycle(1'b1, mk_r(6'h2A, 5'd0), 32'd1, 32'd2, 1'b1);
    chk("slt illegal", 32'(bus.illegal), 32'd1);
    chk("slt out_valid", 32'(bus.out_valid), 32'd0);
    cycle(1'b0, '0, '0, '0, 1'b1);

    // Asynchronous reset with a full buffer.
    cycle(1'b1, mk_r(6'h20, 5'd0), 32'h44, 32'h1, 1'b0);
    cycle(1'b1, mk_r(6'h20, 5'd0), 32'h55, 32'h1, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("async rst A",         bus.A,              32'd0);
    chk("async rst B",         bus.B,              32'd0);
    chk("async rst ALUOp",     32'(bus.ALUOperation), 32'd0);
    chk("async rst Shamt",     32'(bus.Shamt),     32'd0);
    mq.delete();
    exp_ill   = 1'b0;
    exp_iss_n = '0;
    exp_ill_n = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    cycle(1'b1, mk_r(6'h27, 5'd0), 32'h99, 32'h5, 1'b0);
    chk("post rst A", bus.A, 32'h99);
    chk("post rst op", 32'(bus.ALUOperation), 32'h2);
    cycle(1'b0, '0, '0, '0, 1'b1);

    // Random traffic.
    repeat (2000) begin
      cycle(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
            1'($urandom_range(0, 9) < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
